// File: rtl/multichannel_lockin.sv
// Time-multiplexed quadrature lock-in amplifier.
// One shared signed multiplier demodulates every channel against the sin (X)
// and cos (Y) references. Each product feeds its own leaky-integrator low-pass.
//
// state  | meaning
// IDLE   | waiting for tick_i; inputs are captured on the tick
// MUL    | one product per cycle; even idx -> X of channel idx/2, odd idx -> Y
// UPDATE | new x_o/y_o visible, done_o high for this one cycle
module multichannel_lockin #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 24,
    parameter int LPF_SHIFT    = 8,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               tick_i,
    input  logic [DATA_WIDTH-1:0]              sin_i,
    input  logic [DATA_WIDTH-1:0]              cos_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_i,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] x_o,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] y_o,
    output logic                               done_o,
    output logic                               busy_o,
    output logic [COUNT_WIDTH-1:0]             count_o,
    output logic                               overrun_o
);

    localparam int N   = NUM_CHANNELS;
    localparam int DW  = DATA_WIDTH;
    localparam int SW  = DW + LPF_SHIFT + 1;
    localparam int CHW = (N > 1) ? $clog2(N) : 1;
    localparam int IW  = CHW + 1;

    localparam logic [IW-1:0]        IDX_LAST = IW'(2 * N - 1);
    localparam logic signed [DW-1:0] D_MAX    = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] D_MIN    = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [SW-1:0] S_MAX    = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN    = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IW-1:0]           r_idx;
    logic signed [DW-1:0]    r_sin;
    logic signed [DW-1:0]    r_cos;
    logic [N*DW-1:0]         r_data;
    logic signed [SW-1:0]    r_sx [N];
    logic signed [SW-1:0]    r_sy [N];
    logic signed [SW-1:0]    w_sx_nxt [N];
    logic signed [SW-1:0]    w_sy_nxt [N];
    logic [N*DW-1:0]         r_x;
    logic [N*DW-1:0]         r_y;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    r_overrun;

    logic [CHW-1:0]          w_ch_sel;
    logic                    w_is_y;
    logic                    w_last;
    logic signed [DW-1:0]    w_ch;
    logic signed [DW-1:0]    w_ref;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [DW:0]      w_prod_sh;
    logic signed [DW-1:0]    w_m;
    logic signed [SW-1:0]    w_m_ext;
    logic signed [SW-1:0]    w_s_sel;
    logic signed [SW-1:0]    w_s_upd;

    // Filter state scaled back to sample units and clamped to the output range.
    function automatic logic signed [DW-1:0] f_out(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] v;
        v = s >>> LPF_SHIFT;
        if (v > S_MAX)
            f_out = D_MAX;
        else if (v < S_MIN)
            f_out = D_MIN;
        else
            f_out = v[DW-1:0];
    endfunction

    assign w_ch_sel = r_idx[IW-1:1];
    assign w_is_y   = r_idx[0];
    assign w_last   = (r_idx == IDX_LAST);

    // Select the channel sample and the filter state addressed by idx.
    always_comb begin
        w_ch    = '0;
        w_s_sel = '0;
        for (int c = 0; c < N; c++) begin
            if (w_ch_sel == CHW'(c)) begin
                w_ch    = r_data[c*DW +: DW];
                w_s_sel = w_is_y ? r_sy[c] : r_sx[c];
            end
        end
    end

    // Shared multiplier: Q1 x Q1 product, rescaled and saturated. Only
    // (-1)*(-1) can overflow, so the top-two-bit check is sufficient.
    always_comb begin
        w_ref     = w_is_y ? r_cos : r_sin;
        w_prod    = w_ch * w_ref;
        w_prod_sh = w_prod[2*DW-1:DW-1];
        if (w_prod_sh[DW] != w_prod_sh[DW-1])
            w_m = w_prod_sh[DW] ? D_MIN : D_MAX;
        else
            w_m = w_prod_sh[DW-1:0];
        w_m_ext = {{(SW-DW){w_m[DW-1]}}, w_m};
        w_s_upd = w_s_sel + w_m_ext - (w_s_sel >>> LPF_SHIFT);
    end

    // Filter bank as it will be after this cycle; the last MUL cycle loads
    // the outputs from this view so they appear together with done_o.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            w_sx_nxt[c] = r_sx[c];
            w_sy_nxt[c] = r_sy[c];
        end
        if (r_state == ST_MUL) begin
            for (int c = 0; c < N; c++) begin
                if (w_ch_sel == CHW'(c)) begin
                    if (w_is_y)
                        w_sy_nxt[c] = w_s_upd;
                    else
                        w_sx_nxt[c] = w_s_upd;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (tick_i) w_state_nxt = ST_MUL;
            ST_MUL:    if (w_last) w_state_nxt = ST_UPDATE;
            ST_UPDATE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Input capture, filter bank, output registers, counter and overrun flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_idx     <= '0;
            r_sin     <= '0;
            r_cos     <= '0;
            r_data    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            for (int c = 0; c < N; c++) begin
                r_sx[c] <= '0;
                r_sy[c] <= '0;
            end
        end else begin
            if (r_state == ST_IDLE && tick_i) begin
                r_sin  <= sin_i;
                r_cos  <= cos_i;
                r_data <= data_i;
                r_idx  <= '0;
            end
            if (r_state == ST_MUL) begin
                r_idx <= r_idx + 1'b1;
                for (int c = 0; c < N; c++) begin
                    r_sx[c] <= w_sx_nxt[c];
                    r_sy[c] <= w_sy_nxt[c];
                end
                if (w_last) begin
                    for (int c = 0; c < N; c++) begin
                        r_x[c*DW +: DW] <= f_out(w_sx_nxt[c]);
                        r_y[c*DW +: DW] <= f_out(w_sy_nxt[c]);
                    end
                    r_count <= r_count + 1'b1;
                end
            end
            if (tick_i && r_state != ST_IDLE)
                r_overrun <= 1'b1;
        end
    end

    assign x_o       = r_x;
    assign y_o       = r_y;
    assign count_o   = r_count;
    assign overrun_o = r_overrun;
    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = (r_state == ST_UPDATE);

endmodule

// File: tb/tb_multichannel_lockin.sv
// Bench for multichannel_lockin: two instances share the stimulus, one with the
// filter bypassed and a 4-bit counter (A), one with LPF_SHIFT=2 (B).
module tb_multichannel_lockin;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [23:0] sin_v;
    logic [23:0] cos_v;
    logic [95:0] data_v;

    logic [95:0] x_a, y_a, x_b, y_b;
    logic        done_a, busy_a, ovr_a;
    logic        done_b, busy_b, ovr_b;
    logic [3:0]  cnt_a;
    logic [31:0] cnt_b;

    always #5 clk = ~clk;

    multichannel_lockin #(.NUM_CHANNELS(4), .DATA_WIDTH(24), .LPF_SHIFT(0), .COUNT_WIDTH(4)) u_dut_a (
        .clk_i(clk), .reset_i(rst), .tick_i(tick), .sin_i(sin_v), .cos_i(cos_v), .data_i(data_v),
        .x_o(x_a), .y_o(y_a), .done_o(done_a), .busy_o(busy_a), .count_o(cnt_a), .overrun_o(ovr_a));

    multichannel_lockin #(.NUM_CHANNELS(4), .DATA_WIDTH(24), .LPF_SHIFT(2), .COUNT_WIDTH(32)) u_dut_b (
        .clk_i(clk), .reset_i(rst), .tick_i(tick), .sin_i(sin_v), .cos_i(cos_v), .data_i(data_v),
        .x_o(x_b), .y_o(y_b), .done_o(done_b), .busy_o(busy_b), .count_o(cnt_b), .overrun_o(ovr_b));

    typedef struct {
        logic [95:0] x;
        logic [95:0] y;
        logic [31:0] cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;
    int   lat;
    int   seen;
    int   step_x[4] = '{100, 175, 231, 273};

    function automatic logic [95:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {24'(c3), 24'(c2), 24'(c1), 24'(c0)};
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_a(input logic [95:0] x, input logic [95:0] y);
        exp_t e;
        exp_cnt_a = (exp_cnt_a + 1) % 16;
        e.x = x; e.y = y; e.cnt = 32'(exp_cnt_a);
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [95:0] x, input logic [95:0] y);
        exp_t e;
        exp_cnt_b = exp_cnt_b + 1;
        e.x = x; e.y = y; e.cnt = 32'(exp_cnt_b);
        q_b.push_back(e);
    endtask

    task automatic scramble();
        sin_v  = 24'($urandom);
        cos_v  = 24'($urandom);
        data_v = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    // One tick in cycle 0, inputs scrambled from cycle 1, returns the cycle of done_o.
    task automatic issue(input logic [23:0] s, input logic [23:0] c, input logic [95:0] d, output int l);
        @(posedge clk); #1;
        sin_v = s; cos_v = c; data_v = d; tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        scramble();
        l = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done_a) begin
                l = k;
                break;
            end
        end
    endtask

    // Scoreboard monitor: every done pulse is matched against the queued expectation.
    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_a_unexpected actual=pulse expected=none");
            end else begin
                ea = q_a.pop_front();
                chk("a_x", x_a, ea.x);
                chk("a_y", y_a, ea.y);
                chk("a_count", 96'(cnt_a), 96'(ea.cnt));
            end
        end
        if (done_b && q_b.size() != 0) begin
            eb = q_b.pop_front();
            chk("b_x", x_b, eb.x);
            chk("b_y", y_b, eb.y);
            chk("b_count", 96'(cnt_b), 96'(eb.cnt));
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; sin_v = '0; cos_v = '0; data_v = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a | busy_a | ovr_a | done_b | busy_b | ovr_b) seen = 1;
        end
        chk("idle_flags", 96'(seen), 96'd0);
        chk("idle_x", x_a, 96'd0);
        chk("idle_y", y_a, 96'd0);
        chk("idle_cnt", 96'(cnt_a), 96'd0);
        chk("idle_xb", x_b, 96'd0);

        // Basic demodulation, filter bypassed
        push_a(pk(500, 0, 0, -3), pk(-500, 0, 0, 3));
        issue(24'h400000, 24'hC00000, pk(1000, 0, 0, -6), lat);
        chk("lat_basic", 96'(lat), 96'd9);
        chk("ovr_basic", 96'(ovr_a), 96'd0);
        repeat (3) @(negedge clk);
        chk("hold_x", x_a, pk(500, 0, 0, -3));

        // Saturation and truncation toward -inf
        push_a(pk(8388607, -8388607, 1, -3), pk(-4194304, 4194303, -1, 1));
        issue(24'h800000, 24'h400000, pk(-8388608, 8388607, -1, 3), lat);
        chk("lat_sat", 96'(lat), 96'd9);

        // Step response of the LPF_SHIFT=2 instance
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_a(pk(400, 0, 0, 0), 96'd0);
            push_b(pk(step_x[i], 0, 0, 0), 96'd0);
            issue(24'h400000, 24'h000000, pk(800, 0, 0, 0), lat);
            repeat (2) @(posedge clk);
        end
        chk("lat_step", 96'(lat), 96'd9);

        // Overrun: second tick during MUL is ignored
        push_a(pk(500, 0, 0, -3), pk(-500, 0, 0, 3));
        @(posedge clk); #1;
        sin_v = 24'h400000; cos_v = 24'hC00000; data_v = pk(1000, 0, 0, -6); tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        scramble();
        @(negedge clk);
        chk("ovr_before", 96'(ovr_a), 96'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(negedge clk);
        chk("ovr_set", 96'(ovr_a), 96'd1);
        lat = -1;
        for (int k = 4; k <= 40; k++) begin
            if (done_a) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("lat_ovr", 96'(lat), 96'd9);
        repeat (20) @(posedge clk);
        chk("ovr_sticky", 96'(ovr_a), 96'd1);

        // Reset in the middle of processing aborts the sample
        @(posedge clk); #1;
        sin_v = 24'h400000; data_v = pk(1000, 1000, 1000, 1000); tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        chk("abort_no_done", 96'(seen), 96'd0);
        chk("abort_x", x_a, 96'd0);
        chk("abort_y", y_a, 96'd0);
        chk("abort_cnt", 96'(cnt_a), 96'd0);
        chk("abort_ovr", 96'(ovr_a), 96'd0);
        chk("abort_busy", 96'(busy_a), 96'd0);

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 16; i++) begin
            push_a(96'd0, 96'd0);
            issue(24'($urandom), 24'($urandom), 96'd0, lat);
            repeat (2) @(posedge clk);
        end
        chk("lat_wrap", 96'(lat), 96'd9);
        chk("wrap_cnt", 96'(cnt_a), 96'd0);

        repeat (5) @(posedge clk);
        chk("q_a_drained", 96'(q_a.size()), 96'd0);
        chk("q_b_drained", 96'(q_b.size()), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multichannel_lockin.md
Name: multichannel_lockin

Overview:
- Time-multiplexed lock-in amplifier for NUM_CHANNELS signals sharing one quadrature reference (sin/cos), for example from the Hilbert transformer.
- A single shared multiplier demodulates each channel against sin (X) and cos (Y).
- Each product feeds a per-output first-order leaky-integrator low-pass.
- Replaces per-signal lock-in and demodulator instances in the position/OPD chains; adds an update counter and overrun detection.

Parameters:
NUM_CHANNELS, 4, number of demodulated channels (1..16)
DATA_WIDTH, 24, signed width of reference, channel and output samples
LPF_SHIFT, 8, low-pass time constant as a power of two; 0 = filter bypass
COUNT_WIDTH, 32, width of update counter

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
tick_i  in  1  new-sample strobe, one cycle wide
sin_i  in  DATA_WIDTH  signed in-phase reference, Q1.(DATA_WIDTH-1)
cos_i  in  DATA_WIDTH  signed quadrature reference, Q1.(DATA_WIDTH-1)
data_i  in  NUM_CHANNELS*DATA_WIDTH  packed signed channels, channel 0 in the LSBs
x_o  out  NUM_CHANNELS*DATA_WIDTH  packed filtered in-phase outputs
y_o  out  NUM_CHANNELS*DATA_WIDTH  packed filtered quadrature outputs
done_o  out  1  one-cycle pulse when x_o/y_o update
busy_o  out  1  high while a sample is being processed
count_o  out  COUNT_WIDTH  number of completed updates
overrun_o  out  1  sticky flag: tick_i arrived while busy

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - All filter states, x_o, y_o, count_o and the captured registers go to 0.
  - done_o, busy_o and overrun_o go to 0.
  - Reset mid-operation aborts processing; no done_o pulse follows.
- FSM states IDLE, MUL, UPDATE:
  - IDLE: on tick_i, register sin_i, cos_i and all of data_i; idx <= 0; go to MUL. busy_o = 0 in IDLE, 1 in MUL and UPDATE.
  - MUL: lasts 2*NUM_CHANNELS cycles, one product per cycle.
    - idx even: channel idx/2 × sin, updating the X state.
    - idx odd: channel idx/2 × cos, updating the Y state.
    - After idx = 2*NUM_CHANNELS-1, go to UPDATE.
  - UPDATE: copy every filter output to x_o/y_o, pulse done_o, increment count_o, return to IDLE.
- Latency:
  - tick_i in cycle 0 → MUL in cycles 1..2N → done_o and the new outputs in cycle 2N+1.
  - Minimum tick spacing is 2N+2 cycles; x_o/y_o stay constant between done_o pulses.
- Arithmetic:
  - Full product is 2*DATA_WIDTH bits, arithmetic shift right by DATA_WIDTH-1.
  - The result m saturates to [-2^(DW-1), 2^(DW-1)-1]; the only overflow case is (-2^(DW-1))², which gives max positive.
- Filter:
  - State s is signed, DATA_WIDTH+LPF_SHIFT+1 bits.
  - Update: s <= s + m - (s >>> LPF_SHIFT). Output: s >>> LPF_SHIFT, saturated to DATA_WIDTH.
  - DC gain is 1. LPF_SHIFT = 0 gives output = m.
- tick_i while busy (MUL or UPDATE):
  - The tick is ignored and does not affect the current computation.
  - overrun_o is set and stays set until reset.
- count_o wraps from 2^COUNT_WIDTH-1 to 0.
- data_i, sin_i and cos_i are sampled only in the tick_i cycle; changes during MUL have no effect.

Test Plan:
- Reset, then idle for 20 cycles → x_o = y_o = 0, count_o = 0, done_o/busy_o/overrun_o never high.
- N=4, DW=24, LPF_SHIFT=0; sin = 2^22, cos = -2^22, ch0 = 1000, ch3 = -6, one tick at cycle 0 → done_o only at cycle 9; x0 = 500, y0 = -500, x3 = -3, y3 = 3, ch1/ch2 outputs 0, count_o = 1.
- Saturation: LPF_SHIFT=0, sin = ch0 = -2^23 → x0 = 8388607.
- Step response: LPF_SHIFT=2, constant product 400 (ch0 = 800, sin = 2^22), ticks every 12 cycles → x0 = 100, 175, 231, 273 at successive done_o pulses.
- Overrun and reset:
  - Ticks at cycles 0 and 3 → a single done_o at cycle 9, count_o = 1, overrun_o = 1 from cycle 3.
  - Reset at cycle 4 of a new sample → no done_o pulse; outputs 0, overrun_o = 0.
- Wrap: COUNT_WIDTH=4, 16 ticks spaced 12 cycles apart → count_o returns to 0 after the 16th done_o.
